sram_mem_ctrl: RTL and testbench

- Parametrised memory-stage controller that replaces the single-cycle data memory in the 5-stage MIPS pipeline.
- Connects the MEM-stage request (read/write, word address, store value) to an external asynchronous SRAM that is narrower than the pipeline word.
- Each pipeline word is split into BEATS SRAM accesses, and each beat takes WAIT_CYCLES cycles.
- `ready` drives the pipeline-wide freeze, which is asserted whenever `ready` is low.

---
 rtl/mem_ctrl_pkg.sv | 33 +++
 rtl/sram_beat_timer.sv | 54 +++++
 rtl/sram_mem_ctrl.sv | 161 ++++++++++++++++
 tb/tb_sram_mem_ctrl.sv | 419 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// mem_ctrl_pkg
// Shared types and sizing helpers for the SRAM-backed MEM-stage controller.
//   state_t     : controller state encoding (IDLE, ACCESS, DONE)
//   clog2_min1  : ceil(log2(n)) but never narrower than one bit, so counters
//                 sized from it stay legal when there is only one beat
//   BEATS, BEAT_W, CNT_W, BYTE_SHIFT : sizing for the default build
//                 (32-bit pipeline word, 16-bit SRAM, 4 cycles per beat).
//                 Modules with other parameters derive their own copies
//                 from the same helper.
// ---------------------------------------------------------------------------
package mem_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int DEF_DATA_W      = 32;
    localparam int DEF_SRAM_DW     = 16;
    localparam int DEF_WAIT_CYCLES = 4;

    localparam int BEATS      = DEF_DATA_W / DEF_SRAM_DW;
    localparam int BEAT_W     = clog2_min1(BEATS);
    localparam int CNT_W      = clog2_min1(DEF_WAIT_CYCLES);
    localparam int BYTE_SHIFT = $clog2(DEF_DATA_W / 8);

endpackage

// File: rtl/sram_beat_timer.sv
// ---------------------------------------------------------------------------
// sram_beat_timer
// Wait-state / beat counter pair for the SRAM controller. Within a beat the
// count runs 0..WAIT_CYCLES-1; at the end of each beat the count wraps and
// the beat index advances, stopping on the last beat.
// Ports:
//   clk, rst     : clock, synchronous active-low reset
//   clear        : zero both counters (held while the controller is idle)
//   run          : advance the counters this cycle
//   beat         : current beat index
//   count        : current cycle within the beat
//   beat_last    : beat is the final beat of the word
//   access_last  : count is the final cycle of the beat
// ---------------------------------------------------------------------------
module sram_beat_timer
    import mem_ctrl_pkg::clog2_min1;
#(
    parameter int BEATS       = 2,
    parameter int WAIT_CYCLES = 4,
    localparam int BEAT_W     = clog2_min1(BEATS),
    localparam int CNT_W      = clog2_min1(WAIT_CYCLES)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              run,
    output logic [BEAT_W-1:0] beat,
    output logic [CNT_W-1:0]  count,
    output logic              beat_last,
    output logic              access_last
);

    assign beat_last   = (beat == BEAT_W'(BEATS - 1));
    assign access_last = (count == CNT_W'(WAIT_CYCLES - 1));

    // The beat index saturates on the last beat; the controller leaves
    // ACCESS on that same cycle, so it never needs to wrap.
    always_ff @(posedge clk) begin
        if (!rst || clear) begin
            beat  <= '0;
            count <= '0;
        end else if (run) begin
            if (access_last) begin
                count <= '0;
                if (!beat_last) begin
                    beat <= beat + BEAT_W'(1);
                end
            end else begin
                count <= count + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/sram_mem_ctrl.sv
// ---------------------------------------------------------------------------
// sram_mem_ctrl
// MEM-stage data-memory controller in front of a narrow asynchronous SRAM.
// A pipeline word is moved as DATA_W/SRAM_DW beats, least-significant slice
// first, each beat lasting WAIT_CYCLES cycles. 'ready' low freezes the
// pipeline; it pulses high for one cycle (DONE) when the access completes.
// Ports:
//   clk, rst               : clock, synchronous active-low reset
//   rd_en, wr_en           : load / store request (store wins if both set)
//   address                : byte address, BASE_ADDR maps to SRAM word 0
//   wr_data / rd_data      : store value / last load result
//   ready                  : request complete, pipeline frozen while low
//   sram_addr              : SRAM word address
//   sram_dq_out/_oe/_in    : SRAM data bus (out, drive enable, in)
//   sram_we_n, sram_oe_n   : SRAM write strobe / output enable, active-low
// ---------------------------------------------------------------------------
module sram_mem_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int SRAM_DW     = 16,
    parameter int SRAM_AW     = 18,
    parameter int WAIT_CYCLES = 4,
    parameter int BASE_ADDR   = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rd_en,
    input  logic               wr_en,
    input  logic [ADDR_W-1:0]  address,
    input  logic [DATA_W-1:0]  wr_data,
    output logic [DATA_W-1:0]  rd_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    output logic               sram_dq_oe,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_we_n,
    output logic               sram_oe_n
);

    localparam int NUM_BEATS = DATA_W / SRAM_DW;
    localparam int BEAT_BITS = clog2_min1(NUM_BEATS);
    localparam int CNT_BITS  = clog2_min1(WAIT_CYCLES);
    localparam int SHIFT     = $clog2(DATA_W / 8);

    state_t state, state_next;

    logic                 op_wr;
    logic [ADDR_W-1:0]    addr_q;
    logic [DATA_W-1:0]    wdata_q;
    logic [DATA_W-1:0]    rd_data_q;
    logic [ADDR_W-1:0]    word;
    logic [BEAT_BITS-1:0] beat;
    logic [CNT_BITS-1:0]  count;
    logic                 beat_last;
    logic                 access_last;
    logic                 timer_clear;
    logic                 timer_run;
    logic                 request;

    assign request = rd_en | wr_en;
    assign rd_data = rd_data_q;

    // Wrapping subtraction: addresses below BASE_ADDR land at the top of
    // the word space rather than being rejected.
    assign word = (addr_q - ADDR_W'(BASE_ADDR)) >> SHIFT;

    sram_beat_timer #(
        .BEATS       (NUM_BEATS),
        .WAIT_CYCLES (WAIT_CYCLES)
    ) u_timer (
        .clk         (clk),
        .rst         (rst),
        .clear       (timer_clear),
        .run         (timer_run),
        .beat        (beat),
        .count       (count),
        .beat_last   (beat_last),
        .access_last (access_last)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Capture the request once in IDLE; later input changes are ignored
    // until the controller is idle again. A store takes priority over a load.
    always_ff @(posedge clk) begin
        if (!rst) begin
            op_wr   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else if (state == IDLE && request) begin
            op_wr   <= wr_en;
            addr_q  <= address;
            wdata_q <= wr_data;
        end
    end

    // Each read beat lands in its own slice on the beat's last cycle, so
    // the SRAM has had the full wait time to drive valid data.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_data_q <= '0;
        end else if (state == ACCESS && !op_wr && access_last) begin
            rd_data_q[beat*SRAM_DW +: SRAM_DW] <= sram_dq_in;
        end
    end

    // Next-state and SRAM strobes. The write strobe is released on the last
    // cycle of each write beat so data is held past the rising edge of we_n.
    always_comb begin
        state_next  = state;
        ready       = 1'b0;
        timer_clear = 1'b0;
        timer_run   = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        case (state)
            IDLE: begin
                ready       = ~request;
                timer_clear = 1'b1;
                if (request) begin
                    state_next = ACCESS;
                end
            end
            ACCESS: begin
                timer_run = 1'b1;
                sram_addr = SRAM_AW'(word * ADDR_W'(NUM_BEATS) + ADDR_W'(beat));
                if (op_wr) begin
                    sram_dq_oe  = 1'b1;
                    sram_dq_out = wdata_q[beat*SRAM_DW +: SRAM_DW];
                    sram_we_n   = (count == CNT_BITS'(WAIT_CYCLES - 1));
                end else begin
                    sram_oe_n = 1'b0;
                end
                if (access_last && beat_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                ready      = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_sram_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_sram_mem_ctrl
// Bench for sram_mem_ctrl: a default build (32-bit word over 16-bit SRAM,
// 4 cycles per beat) with a behavioural SRAM, and a 32-bit SRAM build with
// 2 cycles per beat. Expected values come from a word-level reference model.
// ---------------------------------------------------------------------------
module tb_sram_mem_ctrl;

    localparam int WAITC  = 4;
    localparam int NBEATS = 2;
    localparam int LAT    = 1 + NBEATS * WAITC;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, wr_data, rd_data;
    logic        ready;
    logic [17:0] sram_addr;
    logic [15:0] sram_dq_out, sram_dq_in;
    logic        sram_dq_oe, sram_we_n, sram_oe_n;

    logic        rd_en_v, wr_en_v;
    logic [31:0] address_v, wr_data_v, rd_data_v;
    logic        ready_v;
    logic [17:0] sram_addr_v;
    logic [31:0] sram_dq_out_v, sram_dq_in_v;
    logic        sram_dq_oe_v, sram_we_n_v, sram_oe_n_v;

    always #5 clk = ~clk;

    sram_mem_ctrl dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .wr_data(wr_data), .rd_data(rd_data), .ready(ready),
        .sram_addr(sram_addr), .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n), .sram_oe_n(sram_oe_n)
    );

    sram_mem_ctrl #(.SRAM_DW(32), .WAIT_CYCLES(2)) dut_v (
        .clk(clk), .rst(rst), .rd_en(rd_en_v), .wr_en(wr_en_v),
        .address(address_v), .wr_data(wr_data_v), .rd_data(rd_data_v), .ready(ready_v),
        .sram_addr(sram_addr_v), .sram_dq_out(sram_dq_out_v), .sram_dq_oe(sram_dq_oe_v),
        .sram_dq_in(sram_dq_in_v), .sram_we_n(sram_we_n_v), .sram_oe_n(sram_oe_n_v)
    );

    // Behavioural asynchronous SRAMs: write while we_n low, read while oe_n low.
    logic [15:0] sram_mem [0:262143];
    logic [31:0] mem_v [0:15];

    always @(posedge clk) begin
        if (!sram_we_n && sram_dq_oe) sram_mem[sram_addr] <= sram_dq_out;
    end
    assign sram_dq_in   = sram_oe_n ? 16'hxxxx : sram_mem[sram_addr];
    assign sram_dq_in_v = sram_oe_n_v ? 32'hxxxxxxxx : mem_v[sram_addr_v[3:0]];

    // Word-level reference model.
    logic [31:0] ref_words [int unsigned];
    logic [31:0] last_rd;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of one transaction, by beat and cycle-within-beat.
    logic        obs_ready0;
    int          obs_cycle;
    logic [31:0] obs_rd;
    logic        obs_idle_ready;
    logic [31:0] obs_rd_after;
    logic [17:0] obs_addr [4];
    logic [15:0] obs_dq   [4];
    logic [3:0]  obs_we   [4];
    logic [3:0]  obs_oe   [4];
    logic [3:0]  obs_dqoe [4];
    int          obs_unstable;

    function automatic int unsigned word_of(input logic [31:0] a);
        logic [31:0] w;
        w = (a - 32'd1024) >> 2;
        return w;
    endfunction

    function automatic logic [17:0] exp_addr(input logic [31:0] a, input int b);
        logic [31:0] w;
        w = (a - 32'd1024) >> 2;
        return 18'(w * 2 + b);
    endfunction

    // Drives one request starting just after a clock edge and records what the
    // SRAM side does. With hold=0 the request inputs are scrambled during the
    // access and one idle cycle is observed afterwards; with hold=1 the inputs
    // stay put and control returns in the cycle after ready.
    task automatic drive_txn(input logic rd, input logic wr, input logic [31:0] a,
                             input logic [31:0] d, input bit hold);
        int bi, pi;
        rd_en = rd; wr_en = wr; address = a; wr_data = d;
        for (int b = 0; b < 4; b++) begin
            obs_addr[b] = 'x; obs_dq[b] = 'x;
            obs_we[b] = '0; obs_oe[b] = '0; obs_dqoe[b] = '0;
        end
        obs_unstable = 0; obs_cycle = -1; obs_rd = 'x;
        @(negedge clk);
        obs_ready0 = ready;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk); #1;
            if (!hold) begin
                rd_en = 1'b0; wr_en = 1'b0; address = $urandom; wr_data = $urandom;
            end
            @(negedge clk);
            if (ready) begin
                obs_cycle = cyc; obs_rd = rd_data;
                break;
            end
            bi = (cyc - 1) / WAITC;
            pi = (cyc - 1) % WAITC;
            if (bi < 4) begin
                if (pi == 0) begin
                    obs_addr[bi] = sram_addr; obs_dq[bi] = sram_dq_out;
                end else if (sram_addr !== obs_addr[bi] ||
                             (sram_dq_oe && sram_dq_out !== obs_dq[bi])) begin
                    obs_unstable++;
                end
                obs_we[bi][pi]   = ~sram_we_n;
                obs_oe[bi][pi]   = ~sram_oe_n;
                obs_dqoe[bi][pi] = sram_dq_oe;
            end
        end
        @(posedge clk); #1;
        if (!hold) begin
            @(negedge clk);
            obs_idle_ready = ready; obs_rd_after = rd_data;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset();
        rst = 1'b0; rd_en = 0; wr_en = 0; address = 0; wr_data = 0;
        rd_en_v = 0; wr_en_v = 0; address_v = 0; wr_data_v = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_dq_oe !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL reset_strobes: got ready=%b we_n=%b oe_n=%b oe=%b expected 1 1 1 0",
                     ready, sram_we_n, sram_oe_n, sram_dq_oe);
        end
        n_checks++;
        if (sram_addr !== 18'h0 || sram_dq_out !== 16'h0 || rd_data !== 32'h0 || rd_data_v !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_values: got addr=%h dq=%h rd=%h rd_v=%h expected all zero",
                     sram_addr, sram_dq_out, rd_data, rd_data_v);
        end
        // Abandon a store part-way through its first beat.
        @(posedge clk); #1;
        wr_en = 1'b1; address = 32'd1028; wr_data = 32'hDEADBEEF;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0; wr_en = 1'b0;
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b1 || sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0 || rd_data !== 32'h0) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_access: got ready=%b we_n=%b oe=%b rd=%h expected 1 1 0 0",
                     ready, sram_we_n, sram_dq_oe, rd_data);
        end
        n_checks++;
        if (sram_addr !== 18'h0 || sram_oe_n !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_mid_access_bus: got addr=%h oe_n=%b expected 0 1", sram_addr, sram_oe_n);
        end
        last_rd = 32'h0;
    endtask

    task automatic test_single_store();
        @(posedge clk); #1;
        drive_txn(1'b0, 1'b1, 32'd1028, 32'hDEADBEEF, 1'b0);
        ref_words[word_of(32'd1028)] = 32'hDEADBEEF;
        n_checks++;
        if (obs_ready0 !== 1'b0 || obs_cycle != LAT) begin
            n_fail++;
            $display("[TB] FAIL store_latency: got ready0=%b cycle=%0d expected 0 %0d", obs_ready0, obs_cycle, LAT);
        end
        n_checks++;
        if (obs_addr[0] !== 18'd2 || obs_addr[1] !== 18'd3) begin
            n_fail++;
            $display("[TB] FAIL store_addr: got %0d %0d expected 2 3", obs_addr[0], obs_addr[1]);
        end
        n_checks++;
        if (obs_dq[0] !== 16'hBEEF || obs_dq[1] !== 16'hDEAD || obs_unstable != 0) begin
            n_fail++;
            $display("[TB] FAIL store_data: got %h %h unstable=%0d expected beef dead 0",
                     obs_dq[0], obs_dq[1], obs_unstable);
        end
        for (int b = 0; b < NBEATS; b++) begin
            n_checks++;
            if (obs_we[b] !== 4'b0111 || obs_dqoe[b] !== 4'b1111 || obs_oe[b] !== 4'b0000) begin
                n_fail++;
                $display("[TB] FAIL store_strobes beat%0d: got we=%b dqoe=%b oe=%b expected 0111 1111 0000",
                         b, obs_we[b], obs_dqoe[b], obs_oe[b]);
            end
        end
        n_checks++;
        if (obs_rd_after !== last_rd) begin
            n_fail++;
            $display("[TB] FAIL store_keeps_rd: got %h expected %h", obs_rd_after, last_rd);
        end
    endtask

    task automatic test_load_after_store();
        @(posedge clk); #1;
        drive_txn(1'b1, 1'b0, 32'd1028, $urandom, 1'b0);
        n_checks++;
        if (obs_cycle != LAT || obs_rd !== 32'hDEADBEEF) begin
            n_fail++;
            $display("[TB] FAIL load_data: got cycle=%0d rd=%h expected %0d deadbeef", obs_cycle, obs_rd, LAT);
        end
        n_checks++;
        if (obs_rd_after !== 32'hDEADBEEF) begin
            n_fail++;
            $display("[TB] FAIL load_hold: got %h expected deadbeef", obs_rd_after);
        end
        n_checks++;
        if (obs_oe[0] !== 4'b1111 || obs_oe[1] !== 4'b1111 || obs_we[0] !== 4'b0 ||
            obs_we[1] !== 4'b0 || obs_dqoe[0] !== 4'b0 || obs_addr[1] !== 18'd3) begin
            n_fail++;
            $display("[TB] FAIL load_strobes: got oe=%b/%b we=%b/%b dqoe=%b addr1=%0d expected 1111/1111 0/0 0 3",
                     obs_oe[0], obs_oe[1], obs_we[0], obs_we[1], obs_dqoe[0], obs_addr[1]);
        end
        last_rd = 32'hDEADBEEF;
    endtask

    task automatic test_simultaneous();
        @(posedge clk); #1;
        drive_txn(1'b1, 1'b1, 32'd1024, 32'h12345678, 1'b0);
        ref_words[word_of(32'd1024)] = 32'h12345678;
        n_checks++;
        if (obs_oe[0] !== 4'b0 || obs_oe[1] !== 4'b0 || obs_we[0] !== 4'b0111 || obs_we[1] !== 4'b0111) begin
            n_fail++;
            $display("[TB] FAIL both_write_only: got oe=%b/%b we=%b/%b expected 0000/0000 0111/0111",
                     obs_oe[0], obs_oe[1], obs_we[0], obs_we[1]);
        end
        n_checks++;
        if (obs_dq[0] !== 16'h5678 || obs_dq[1] !== 16'h1234 || obs_addr[0] !== 18'd0 || obs_addr[1] !== 18'd1) begin
            n_fail++;
            $display("[TB] FAIL both_beats: got %h@%0d %h@%0d expected 5678@0 1234@1",
                     obs_dq[0], obs_addr[0], obs_dq[1], obs_addr[1]);
        end
        n_checks++;
        if (obs_cycle != LAT || obs_rd !== last_rd || obs_rd_after !== last_rd) begin
            n_fail++;
            $display("[TB] FAIL both_rd_kept: got cycle=%0d rd=%h/%h expected %0d %h",
                     obs_cycle, obs_rd, obs_rd_after, LAT, last_rd);
        end
        drive_txn(1'b1, 1'b0, 32'd1024, 32'h0, 1'b0);
        n_checks++;
        if (obs_rd !== 32'h12345678) begin
            n_fail++;
            $display("[TB] FAIL both_readback: got %h expected 12345678", obs_rd);
        end
        last_rd = 32'h12345678;
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        d = $urandom;
        @(posedge clk); #1;
        drive_txn(1'b0, 1'b1, 32'd1036, d, 1'b1);
        ref_words[word_of(32'd1036)] = d;
        n_checks++;
        if (obs_cycle != LAT) begin
            n_fail++;
            $display("[TB] FAIL b2b_write_cycle: got %0d expected %0d", obs_cycle, LAT);
        end
        // Now in the IDLE cycle after DONE; the load is presented immediately.
        drive_txn(1'b1, 1'b0, 32'd1036, 32'h0, 1'b0);
        n_checks++;
        if (obs_ready0 !== 1'b0 || obs_cycle != LAT) begin
            n_fail++;
            $display("[TB] FAIL b2b_read_timing: got ready0=%b cycle=%0d expected 0 %0d",
                     obs_ready0, obs_cycle, LAT);
        end
        n_checks++;
        if (obs_rd !== d || obs_addr[0] !== 18'd6 || obs_addr[1] !== 18'd7) begin
            n_fail++;
            $display("[TB] FAIL b2b_read_data: got %h@%0d/%0d expected %h@6/7", obs_rd, obs_addr[0], obs_addr[1], d);
        end
        last_rd = d;
    endtask

    task automatic test_address_wrap();
        logic [31:0] d;
        d = $urandom;
        @(posedge clk); #1;
        drive_txn(1'b0, 1'b1, 32'd1020, d, 1'b0);
        ref_words[word_of(32'd1020)] = d;
        n_checks++;
        if (obs_addr[0] !== 18'h3FFFE || obs_addr[1] !== 18'h3FFFF) begin
            n_fail++;
            $display("[TB] FAIL wrap_addr: got %h %h expected 3fffe 3ffff", obs_addr[0], obs_addr[1]);
        end
        drive_txn(1'b1, 1'b0, 32'd1020, 32'h0, 1'b0);
        n_checks++;
        if (obs_rd !== d) begin
            n_fail++;
            $display("[TB] FAIL wrap_readback: got %h expected %h", obs_rd, d);
        end
        last_rd = d;
    endtask

    task automatic test_random();
        int unsigned written [$];
        int          op;
        logic [31:0] a, d, exp;
        for (int i = 0; i < 24; i++) begin
            op = $urandom_range(0, 2);
            if (op == 0 && written.size() == 0) op = 1;
            if (op == 0) a = 32'd1024 + 4 * written[$urandom_range(0, written.size() - 1)] + $urandom_range(0, 3);
            else         a = 32'd1024 + 4 * $urandom_range(0, 255) + $urandom_range(0, 3);
            d = $urandom;
            @(posedge clk); #1;
            drive_txn(op != 1, op != 0, a, d, 1'b0);
            n_checks++;
            if (obs_cycle != LAT || obs_unstable != 0) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_timing: got cycle=%0d unstable=%0d expected %0d 0",
                         i, obs_cycle, obs_unstable, LAT);
            end
            for (int b = 0; b < NBEATS; b++) begin
                n_checks++;
                if (obs_addr[b] !== exp_addr(a, b)) begin
                    n_fail++;
                    $display("[TB] FAIL rand%0d_addr beat%0d: got %h expected %h", i, b, obs_addr[b], exp_addr(a, b));
                end
                if (op != 0) begin
                    n_checks++;
                    if (obs_dq[b] !== 16'((d >> (16 * b)) & 32'hFFFF) || obs_we[b] !== 4'b0111 || obs_oe[b] !== 4'b0) begin
                        n_fail++;
                        $display("[TB] FAIL rand%0d_write beat%0d: got dq=%h we=%b oe=%b expected %h 0111 0000",
                                 i, b, obs_dq[b], obs_we[b], obs_oe[b], 16'((d >> (16 * b)) & 32'hFFFF));
                    end
                end else begin
                    n_checks++;
                    if (obs_oe[b] !== 4'b1111 || obs_we[b] !== 4'b0) begin
                        n_fail++;
                        $display("[TB] FAIL rand%0d_read beat%0d: got oe=%b we=%b expected 1111 0000",
                                 i, b, obs_oe[b], obs_we[b]);
                    end
                end
            end
            if (op != 0) begin
                ref_words[word_of(a)] = d;
                written.push_back(word_of(a));
                exp = last_rd;
            end else begin
                exp = ref_words[word_of(a)];
                last_rd = exp;
            end
            n_checks++;
            if (obs_rd !== exp || obs_rd_after !== exp) begin
                n_fail++;
                $display("[TB] FAIL rand%0d_rd_data: got %h/%h expected %h", i, obs_rd, obs_rd_after, exp);
            end
        end
    endtask

    task automatic test_param_variant();
        logic [31:0] v;
        int          rcyc;
        logic [17:0] a1;
        logic        strobes_ok;
        v = $urandom;
        mem_v[2] = v;
        rcyc = -1; a1 = 'x; strobes_ok = 1'b1;
        @(posedge clk); #1;
        rd_en_v = 1'b1; address_v = 32'd1032;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            @(posedge clk); #1;
            rd_en_v = 1'b0; address_v = $urandom;
            @(negedge clk);
            if (ready_v) begin
                rcyc = cyc;
                break;
            end
            if (cyc == 1) a1 = sram_addr_v;
            if (sram_oe_n_v !== 1'b0 || sram_we_n_v !== 1'b1 || sram_dq_oe_v !== 1'b0) strobes_ok = 1'b0;
        end
        n_checks++;
        if (rcyc != 3 || a1 !== 18'd2) begin
            n_fail++;
            $display("[TB] FAIL variant_timing: got cycle=%0d addr=%0d expected 3 2", rcyc, a1);
        end
        n_checks++;
        if (rd_data_v !== v || !strobes_ok) begin
            n_fail++;
            $display("[TB] FAIL variant_data: got %h strobes_ok=%b expected %h 1", rd_data_v, strobes_ok, v);
        end
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] sram_mem_ctrl bench start");
        test_reset();
        test_single_store();
        test_load_after_store();
        test_simultaneous();
        test_back_to_back();
        test_address_wrap();
        test_random();
        test_param_variant();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
